network_output_stage: RTL and testbench

- Consumes the packed result vector of the final conv layer (D lanes of W bits, plus its valid level) and produces the four sample outputs to the codec.
- Selects four lanes, applies a saturating left shift to undo input pre-scaling, and double-buffers the results so outputs change only on sample_clk rising edges.
- Detects sample periods where no result arrived, counts them, and mutes the outputs after a run of misses.

---
 rtl/network_output_stage_pkg.sv | 27 ++
 rtl/network_output_stage_if.sv | 33 +++
 rtl/network_output_stage_sat_shl.sv | 32 +++
 rtl/network_output_stage.sv | 176 +++++++++++++++++
 tb/tb_network_output_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/network_output_stage_pkg.sv
// Shared types and constants for the network output stage.
// Provides the default lane geometry, the lane type, counter ceilings
// and a lane-extract helper for the default packed-vector layout.
package network_pkg;

    localparam int W_DEF     = 16;
    localparam int D_DEF     = 8;
    localparam int SEL_W_DEF = $clog2(D_DEF);

    typedef logic signed [W_DEF-1:0] lane_t;

    localparam logic [3:0] MISS_CNT_MAX = 4'd15;
    localparam logic [7:0] OVERRUN_MAX  = 8'd255;

    // Lane k occupies the k-th W-bit slot counted from the MSB end.
    // Out-of-range indices fall back to lane 0.
    function automatic lane_t lane_extract(input logic [D_DEF*W_DEF-1:0] vec,
                                           input logic [SEL_W_DEF-1:0]   idx);
        int unsigned i;
        i = 32'(idx);
        if (i >= D_DEF) begin
            i = 0;
        end
        return vec[(D_DEF-1-i)*W_DEF +: W_DEF];
    endfunction

endpackage

// File: rtl/network_output_stage_if.sv
// Bus between the final conv layer / codec side and the output stage.
// master: the environment driving results and sample clock.
// slave: the output stage itself.
interface network_output_stage_if #(
    parameter int W = 16,
    parameter int D = 8
);
    localparam int SEL_W = $clog2(D);

    logic                   sample_clk;
    logic [D*W-1:0]         in_packed;
    logic                   in_v;
    logic [4*SEL_W-1:0]     ch_sel;
    logic signed [W-1:0]    sample_out0;
    logic signed [W-1:0]    sample_out1;
    logic signed [W-1:0]    sample_out2;
    logic signed [W-1:0]    sample_out3;
    logic                   stale;
    logic [7:0]             overrun_count;

    modport master (
        output sample_clk, in_packed, in_v, ch_sel,
        input  sample_out0, sample_out1, sample_out2, sample_out3,
        input  stale, overrun_count
    );

    modport slave (
        input  sample_clk, in_packed, in_v, ch_sel,
        output sample_out0, sample_out1, sample_out2, sample_out3,
        output stale, overrun_count
    );

endinterface

// File: rtl/network_output_stage_sat_shl.sv
// Combinational saturating arithmetic left shift of one signed sample.
// The shift is done at full precision and clamped to the W-bit range.
module sat_shl #(
    parameter int W     = 16,
    parameter int SHIFT = 2
) (
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    // Overflow shows up as the bits above the W-bit sign not all matching it.
    function automatic logic signed [W-1:0] sat_shift(input logic signed [W-1:0] x);
        logic signed [W+SHIFT-1:0] wide;
        logic [SHIFT:0]            upper;
        wide  = x;
        wide  = wide <<< SHIFT;
        upper = wide[W+SHIFT-1 -: SHIFT+1];
        if ((&upper) || (~|upper)) begin
            return wide[W-1:0];
        end
        return wide[W+SHIFT-1] ? MIN_V : MAX_V;
    endfunction

    // Pure combinational clamp, no state.
    always_comb begin
        dout = sat_shift(din);
    end

endmodule

// File: rtl/network_output_stage.sv
// Output stage of the network: picks four lanes of the final conv result,
// undoes input pre-scaling with a saturating shift, holds the result in a
// pending buffer and releases it on the next sample_clk rising edge.
// Missed periods are counted and the outputs are muted after a run of them.
// Optional build macro OUTPUT_SMOOTH_EN: one-pole smoothing (alpha 1/4)
// applied at each transfer instead of a direct copy.
module network_output_stage
    import network_pkg::*;
#(
    parameter int W          = network_pkg::W_DEF,
    parameter int D          = network_pkg::D_DEF,
    parameter int SHIFT      = 2,
    parameter int MISS_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    network_output_stage_if.slave   bus
);

    localparam int SEL_W = $clog2(D);
    localparam logic [3:0] LIMIT4 = 4'(MISS_LIMIT);

    typedef logic signed [W-1:0] samp_t;
    typedef enum logic { CAPTURE_OPEN = 1'b0, CAPTURE_DONE = 1'b1 } cap_state_t;

    cap_state_t state_q, state_d;
    logic       capture_en;
    logic       prev_sample_clk;
    logic       edge_det;
    logic       pending_full;
    logic [3:0] miss_cnt;
    logic [3:0] miss_inc;
    logic [7:0] overrun_cnt;
    logic [7:0] overrun_inc;
    logic       stale_q;

    samp_t lane_sel   [4];
    samp_t sat_v      [4];
    samp_t pending_p0 [4];
    samp_t out_p1     [4];

`ifdef OUTPUT_SMOOTH_EN
    localparam samp_t MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam samp_t MIN_V = {1'b1, {(W-1){1'b0}}};

    function automatic samp_t sat_w1(input logic signed [W:0] s);
        if (s[W] != s[W-1]) begin
            return s[W] ? MIN_V : MAX_V;
        end
        return s[W-1:0];
    endfunction

    function automatic samp_t smooth(input samp_t y, input samp_t p);
        logic signed [W:0] y_e, p_e, d, s;
        y_e = y;
        p_e = p;
        d   = p_e - y_e;
        s   = y_e + (d >>> 2);
        return sat_w1(s);
    endfunction
`endif

    assign edge_det    = bus.sample_clk & ~prev_sample_clk;
    assign miss_inc    = (miss_cnt == MISS_CNT_MAX) ? miss_cnt : miss_cnt + 4'd1;
    assign overrun_inc = (overrun_cnt == OVERRUN_MAX) ? overrun_cnt : overrun_cnt + 8'd1;

    // Lane selection: out0 index sits in the MSBs of ch_sel.
    generate
        if (W == W_DEF && D == D_DEF) begin : g_sel_pkg
            always_comb begin
                for (int k = 0; k < 4; k++) begin
                    lane_sel[k] = lane_extract(bus.in_packed, bus.ch_sel[(3-k)*SEL_W +: SEL_W]);
                end
            end
        end else begin : g_sel_gen
            always_comb begin
                for (int k = 0; k < 4; k++) begin
                    int unsigned i;
                    i = 32'(bus.ch_sel[(3-k)*SEL_W +: SEL_W]);
                    if (i >= D) begin
                        i = 0;
                    end
                    lane_sel[k] = bus.in_packed[(D-1-i)*W +: W];
                end
            end
        end
    endgenerate

    for (genvar g = 0; g < 4; g++) begin : g_sat
        sat_shl #(.W(W), .SHIFT(SHIFT)) u_sat (
            .din  (lane_sel[g]),
            .dout (sat_v[g])
        );
    end

    // Capture FSM register: tracks whether this period already captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CAPTURE_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state; an edge opens the new period in the same cycle,
    // so a result arriving on the edge belongs to the new period.
    always_comb begin
        capture_en = 1'b0;
        state_d    = state_q;
        if (bus.in_v && (state_q == CAPTURE_OPEN || edge_det)) begin
            capture_en = 1'b1;
            state_d    = CAPTURE_DONE;
        end else if (edge_det) begin
            state_d    = CAPTURE_OPEN;
        end
    end

    // Stage p0: pending buffer of saturated lane values.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int k = 0; k < 4; k++) begin
                pending_p0[k] <= sat_v[k];
            end
        end
    end

    // Stage p1: transfer on sample edge, miss accounting and muting.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample_clk <= 1'b0;
            pending_full    <= 1'b0;
            miss_cnt        <= '0;
            overrun_cnt     <= '0;
            stale_q         <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                out_p1[k] <= '0;
            end
        end else begin
            prev_sample_clk <= bus.sample_clk;
            if (edge_det) begin
                if (pending_full) begin
                    for (int k = 0; k < 4; k++) begin
`ifdef OUTPUT_SMOOTH_EN
                        out_p1[k] <= smooth(out_p1[k], pending_p0[k]);
`else
                        out_p1[k] <= pending_p0[k];
`endif
                    end
                    miss_cnt     <= '0;
                    stale_q      <= 1'b0;
                    pending_full <= 1'b0;
                end else begin
                    miss_cnt    <= miss_inc;
                    overrun_cnt <= overrun_inc;
                    if (miss_inc >= LIMIT4) begin
                        for (int k = 0; k < 4; k++) begin
                            out_p1[k] <= '0;
                        end
                        stale_q <= 1'b1;
                    end
                end
            end
            if (capture_en) begin
                pending_full <= 1'b1;
            end
        end
    end

    assign bus.sample_out0   = out_p1[0];
    assign bus.sample_out1   = out_p1[1];
    assign bus.sample_out2   = out_p1[2];
    assign bus.sample_out3   = out_p1[3];
    assign bus.stale         = stale_q;
    assign bus.overrun_count = overrun_cnt;

endmodule

// File: tb/tb_network_output_stage.sv
// Directed bench for network_output_stage with hand-computed expectations.
module tb_network_output_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    network_output_stage_if #(.W(16), .D(8)) bus ();

    network_output_stage #(.W(16), .D(8), .SHIFT(2), .MISS_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [15:0] l0, input logic [15:0] l1,
                             input logic [15:0] l2, input logic [15:0] l3);
        bus.in_packed = {l0, l1, l2, l3, 64'h0};
    endtask

    task automatic pulse_valid();
        bus.in_v = 1'b1;
        tick();
        bus.in_v = 1'b0;
        tick();
    endtask

    task automatic do_edge();
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        tick();
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        check_val({tag, "_o0"}, bus.sample_out0, e0);
        check_val({tag, "_o1"}, bus.sample_out1, e1);
        check_val({tag, "_o2"}, bus.sample_out2, e2);
        check_val({tag, "_o3"}, bus.sample_out3, e3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.sample_clk = 1'b0;
        bus.in_v       = 1'b0;
        bus.in_packed  = '0;
        bus.ch_sel     = {3'd0, 3'd1, 3'd2, 3'd3};
        tick();
        tick();
        rst = 1'b0;
        tick();

        check_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        check_val("reset_stale", 16'(bus.stale), 16'h0);
        check_val("reset_ovr", 16'(bus.overrun_count), 16'h0);

        // Basic transfer
        set_lanes(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
        pulse_valid();
        tick();
        check_val("basic_pre_edge", bus.sample_out0, 16'h0000);
        do_edge();
        check_outs("basic", 16'h0400, 16'h0800, 16'hFC00, 16'h0000);
        check_val("basic_ovr", 16'(bus.overrun_count), 16'h0);

        // Saturation
        set_lanes(16'h2000, 16'hC000, 16'h1FFF, 16'h0001);
        pulse_valid();
        do_edge();
        check_outs("sat", 16'h7FFF, 16'h8000, 16'h7FFC, 16'h0004);

        // Misses
        set_lanes(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        pulse_valid();
        do_edge();
        check_val("miss_start", bus.sample_out0, 16'h0400);
        for (int n = 1; n <= 3; n++) begin
            do_edge();
            check_val($sformatf("miss%0d_o0", n), bus.sample_out0, 16'h0400);
            check_val($sformatf("miss%0d_stale", n), 16'(bus.stale), 16'h0);
            check_val($sformatf("miss%0d_ovr", n), 16'(bus.overrun_count), 16'(n));
        end
        do_edge();
        check_val("miss4_o0", bus.sample_out0, 16'h0000);
        check_val("miss4_stale", 16'(bus.stale), 16'h1);
        check_val("miss4_ovr", 16'(bus.overrun_count), 16'h4);
        set_lanes(16'h0200, 16'h0000, 16'h0000, 16'h0000);
        pulse_valid();
        do_edge();
        check_val("recover_o0", bus.sample_out0, 16'h0800);
        check_val("recover_stale", 16'(bus.stale), 16'h0);
        check_val("recover_ovr", 16'(bus.overrun_count), 16'h4);

        // Same-cycle collision: A pending, B arrives on the edge cycle
        set_lanes(16'h0010, 16'h0000, 16'h0000, 16'h0000);
        pulse_valid();
        set_lanes(16'h0020, 16'h0000, 16'h0000, 16'h0000);
        bus.sample_clk = 1'b1;
        bus.in_v       = 1'b1;
        tick();
        bus.in_v       = 1'b0;
        check_val("coll_a", bus.sample_out0, 16'h0040);
        bus.sample_clk = 1'b0;
        tick();
        do_edge();
        check_val("coll_b", bus.sample_out0, 16'h0080);
        check_val("coll_ovr", 16'(bus.overrun_count), 16'h4);

        // Upper lane indices
        bus.in_packed = {64'h0, 16'h4000, 16'h0003, 16'hFFFF, 16'h0001};
        bus.ch_sel    = {3'd7, 3'd6, 3'd5, 3'd4};
        pulse_valid();
        do_edge();
        check_outs("hisel", 16'h0004, 16'hFFFC, 16'h000C, 16'h7FFF);
        bus.ch_sel    = {3'd0, 3'd1, 3'd2, 3'd3};

        // Held valid: only the first cycle's lanes are captured
        set_lanes(16'h0005, 16'h0000, 16'h0000, 16'h0000);
        bus.in_v = 1'b1;
        tick();
        set_lanes(16'h0007, 16'h0000, 16'h0000, 16'h0000);
        for (int n = 0; n < 49; n++) begin
            tick();
        end
        bus.in_v = 1'b0;
        tick();
        do_edge();
        check_val("hold_o0", bus.sample_out0, 16'h0014);
        check_val("hold_ovr", 16'(bus.overrun_count), 16'h4);

        // Reset with pending full discards the pending result
        set_lanes(16'h0009, 16'h0001, 16'h0000, 16'h0000);
        pulse_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0);
        check_val("rst_mid_ovr", 16'(bus.overrun_count), 16'h0);
        do_edge();
        check_val("rst_edge_o0", bus.sample_out0, 16'h0000);
        check_val("rst_edge_o1", bus.sample_out1, 16'h0000);
        check_val("rst_edge_ovr", 16'(bus.overrun_count), 16'h1);
        check_val("rst_edge_stale", 16'(bus.stale), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
